// File: rtl/writeback_controller_pkg.sv
// Shared core definitions for the writeback stage.
// Holds register address and datapath widths plus the buffer FSM state type.
// Imported by writeback_controller and wb_buffer.
package writeback_controller_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SCALAR_W   = 32;
  localparam int VECTOR_W   = 128;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_buf_state_t;

endpackage

// File: rtl/wb_buffer.sv
// Single-entry holding buffer for a vector-pipeline result that lost its write port.
// Latency: captured entry is presented combinationally from the cycle after capture.
// Backpressure: none upstream; a capture into a FULL, non-draining buffer is dropped and flagged sticky.
module wb_buffer
  import writeback_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en,
  input  logic [REG_ADDR_W-1:0] cap_addr,
  input  logic [WIDTH-1:0]      cap_data,
  input  logic                  drain_sel,
  input  logic                  port_busy,
  output logic                  drain,
  output logic [REG_ADDR_W-1:0] entry_addr,
  output logic [WIDTH-1:0]      entry_data,
  output logic                  ovf
);

  wb_buf_state_t state;
  wb_buf_state_t state_nxt;
  logic          load;
  logic          ovf_set;

  // Drain on explicit request, or opportunistically when nobody else wants the port.
  always_comb begin
    drain     = (state == FULL) && (drain_sel || !port_busy);
    load      = 1'b0;
    state_nxt = state;
    ovf_set   = 1'b0;
    case (state)
      EMPTY: begin
        if (cap_en) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (drain) begin
          // Old entry leaves this cycle, so a simultaneous capture refills in place.
          if (cap_en) begin
            load = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end else if (cap_en) begin
          // No room: keep the older result, drop the new one.
          ovf_set = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // FSM state, entry storage and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      entry_addr <= '0;
      entry_data <= '0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        entry_addr <= cap_addr;
        entry_data <= cap_data;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_controller.sv
// Arbitrates scalar, vector-direct and buffered vector results onto the RF and VRF write ports.
// Latency: one cycle from winning arbitration to the registered write-port outputs.
// Backpressure: wb_stall (combinational) holds the scalar pipeline when its result loses a port.
module writeback_controller #(
  parameter int SCALAR_W = writeback_controller_pkg::SCALAR_W,
  parameter int VECTOR_W = writeback_controller_pkg::VECTOR_W
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        s_reg_wr_en,
  input  logic                                        s_vec_wr_en,
  input  logic [writeback_controller_pkg::REG_ADDR_W-1:0] s_wr_reg,
  input  logic [SCALAR_W-1:0]                         s_reg_data,
  input  logic [VECTOR_W-1:0]                         s_vec_data,
  input  logic                                        v_reg_wr_en,
  input  logic                                        v_vec_wr_en,
  input  logic [writeback_controller_pkg::REG_ADDR_W-1:0] v_wr_reg,
  input  logic [SCALAR_W-1:0]                         v_reg_data,
  input  logic [VECTOR_W-1:0]                         v_vec_data,
  input  logic                                        register_wb_sel,
  input  logic                                        vector_wb_sel,
  input  logic                                        buffer_register,
  input  logic                                        buffer_vector,
  input  logic                                        buffer_register_sel,
  input  logic                                        buffer_vector_sel,
  output logic                                        rf_wr_en,
  output logic [writeback_controller_pkg::REG_ADDR_W-1:0] rf_wr_addr,
  output logic [SCALAR_W-1:0]                         rf_wr_data,
  output logic                                        vrf_wr_en,
  output logic [writeback_controller_pkg::REG_ADDR_W-1:0] vrf_wr_addr,
  output logic [VECTOR_W-1:0]                         vrf_wr_data,
  output logic                                        wb_stall,
  output logic                                        buf_ovf
);

  import writeback_controller_pkg::*;

  // RF port request terms
  logic                  rf_cap;
  logic                  rf_vdir;
  logic                  rf_busy;
  logic                  rf_drain;
  logic                  rf_lose;
  logic [REG_ADDR_W-1:0] rf_buf_addr;
  logic [SCALAR_W-1:0]   rf_buf_data;
  logic                  rf_ovf;
  logic                  rf_sel_en;
  logic [REG_ADDR_W-1:0] rf_sel_addr;
  logic [SCALAR_W-1:0]   rf_sel_data;

  // VRF port request terms
  logic                  vrf_cap;
  logic                  vrf_vdir;
  logic                  vrf_busy;
  logic                  vrf_drain;
  logic                  vrf_lose;
  logic [REG_ADDR_W-1:0] vrf_buf_addr;
  logic [VECTOR_W-1:0]   vrf_buf_data;
  logic                  vrf_ovf;
  logic                  vrf_sel_en;
  logic [REG_ADDR_W-1:0] vrf_sel_addr;
  logic [VECTOR_W-1:0]   vrf_sel_data;

  // A buffer request without a valid vector result carries nothing to hold.
  assign rf_cap   = buffer_register & v_reg_wr_en;
  assign vrf_cap  = buffer_vector   & v_vec_wr_en;

  // Vector result goes straight to the port only when granted and not being buffered.
  assign rf_vdir  = register_wb_sel & ~buffer_register & v_reg_wr_en;
  assign vrf_vdir = vector_wb_sel   & ~buffer_vector   & v_vec_wr_en;

  // Any competing request blocks an opportunistic drain.
  assign rf_busy  = rf_vdir  | s_reg_wr_en;
  assign vrf_busy = vrf_vdir | s_vec_wr_en;

  wb_buffer #(
    .WIDTH (SCALAR_W)
  ) u_rf_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en     (rf_cap),
    .cap_addr   (v_wr_reg),
    .cap_data   (v_reg_data),
    .drain_sel  (buffer_register_sel),
    .port_busy  (rf_busy),
    .drain      (rf_drain),
    .entry_addr (rf_buf_addr),
    .entry_data (rf_buf_data),
    .ovf        (rf_ovf)
  );

  wb_buffer #(
    .WIDTH (VECTOR_W)
  ) u_vrf_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en     (vrf_cap),
    .cap_addr   (v_wr_reg),
    .cap_data   (v_vec_data),
    .drain_sel  (buffer_vector_sel),
    .port_busy  (vrf_busy),
    .drain      (vrf_drain),
    .entry_addr (vrf_buf_addr),
    .entry_data (vrf_buf_data),
    .ovf        (vrf_ovf)
  );

  // Scalar loses whenever a higher-priority source takes its port.
  assign rf_lose  = s_reg_wr_en & (rf_drain  | rf_vdir);
  assign vrf_lose = s_vec_wr_en & (vrf_drain | vrf_vdir);
  assign wb_stall = rst_n & (rf_lose | vrf_lose);

  assign buf_ovf  = rf_ovf | vrf_ovf;

  // RF port winner: buffer drain, then vector direct, then scalar.
  always_comb begin
    rf_sel_en   = 1'b0;
    rf_sel_addr = '0;
    rf_sel_data = '0;
    if (rf_drain) begin
      rf_sel_en   = 1'b1;
      rf_sel_addr = rf_buf_addr;
      rf_sel_data = rf_buf_data;
    end else if (rf_vdir) begin
      rf_sel_en   = 1'b1;
      rf_sel_addr = v_wr_reg;
      rf_sel_data = v_reg_data;
    end else if (s_reg_wr_en) begin
      rf_sel_en   = 1'b1;
      rf_sel_addr = s_wr_reg;
      rf_sel_data = s_reg_data;
    end
  end

  // VRF port winner: same priority order as the RF port.
  always_comb begin
    vrf_sel_en   = 1'b0;
    vrf_sel_addr = '0;
    vrf_sel_data = '0;
    if (vrf_drain) begin
      vrf_sel_en   = 1'b1;
      vrf_sel_addr = vrf_buf_addr;
      vrf_sel_data = vrf_buf_data;
    end else if (vrf_vdir) begin
      vrf_sel_en   = 1'b1;
      vrf_sel_addr = v_wr_reg;
      vrf_sel_data = v_vec_data;
    end else if (s_vec_wr_en) begin
      vrf_sel_en   = 1'b1;
      vrf_sel_addr = s_wr_reg;
      vrf_sel_data = s_vec_data;
    end
  end

  // Register both write ports; address/data hold their last value while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      vrf_wr_en   <= 1'b0;
      vrf_wr_addr <= '0;
      vrf_wr_data <= '0;
    end else begin
      rf_wr_en  <= rf_sel_en;
      vrf_wr_en <= vrf_sel_en;
      if (rf_sel_en) begin
        rf_wr_addr <= rf_sel_addr;
        rf_wr_data <= rf_sel_data;
      end
      if (vrf_sel_en) begin
        vrf_wr_addr <= vrf_sel_addr;
        vrf_wr_data <= vrf_sel_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_controller.sv
module tb_writeback_controller;

  logic         clk;
  logic         rst_n;
  logic         s_reg_wr_en;
  logic         s_vec_wr_en;
  logic [4:0]   s_wr_reg;
  logic [31:0]  s_reg_data;
  logic [127:0] s_vec_data;
  logic         v_reg_wr_en;
  logic         v_vec_wr_en;
  logic [4:0]   v_wr_reg;
  logic [31:0]  v_reg_data;
  logic [127:0] v_vec_data;
  logic         register_wb_sel;
  logic         vector_wb_sel;
  logic         buffer_register;
  logic         buffer_vector;
  logic         buffer_register_sel;
  logic         buffer_vector_sel;
  logic         rf_wr_en;
  logic [4:0]   rf_wr_addr;
  logic [31:0]  rf_wr_data;
  logic         vrf_wr_en;
  logic [4:0]   vrf_wr_addr;
  logic [127:0] vrf_wr_data;
  logic         wb_stall;
  logic         buf_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_controller dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_reg_wr_en         (s_reg_wr_en),
    .s_vec_wr_en         (s_vec_wr_en),
    .s_wr_reg            (s_wr_reg),
    .s_reg_data          (s_reg_data),
    .s_vec_data          (s_vec_data),
    .v_reg_wr_en         (v_reg_wr_en),
    .v_vec_wr_en         (v_vec_wr_en),
    .v_wr_reg            (v_wr_reg),
    .v_reg_data          (v_reg_data),
    .v_vec_data          (v_vec_data),
    .register_wb_sel     (register_wb_sel),
    .vector_wb_sel       (vector_wb_sel),
    .buffer_register     (buffer_register),
    .buffer_vector       (buffer_vector),
    .buffer_register_sel (buffer_register_sel),
    .buffer_vector_sel   (buffer_vector_sel),
    .rf_wr_en            (rf_wr_en),
    .rf_wr_addr          (rf_wr_addr),
    .rf_wr_data          (rf_wr_data),
    .vrf_wr_en           (vrf_wr_en),
    .vrf_wr_addr         (vrf_wr_addr),
    .vrf_wr_data         (vrf_wr_data),
    .wb_stall            (wb_stall),
    .buf_ovf             (buf_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         s_reg_wr_en;
    logic         s_vec_wr_en;
    logic [4:0]   s_wr_reg;
    logic [31:0]  s_reg_data;
    logic [127:0] s_vec_data;
    logic         v_reg_wr_en;
    logic         v_vec_wr_en;
    logic [4:0]   v_wr_reg;
    logic [31:0]  v_reg_data;
    logic [127:0] v_vec_data;
    logic         register_wb_sel;
    logic         vector_wb_sel;
    logic         e_stall;
    logic         e_rf_en;
    logic [4:0]   e_rf_addr;
    logic [31:0]  e_rf_data;
    logic         e_vrf_en;
    logic [4:0]   e_vrf_addr;
    logic [127:0] e_vrf_data;
  } vec_t;

  localparam int NVEC = 12;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_reg_wr_en         = 1'b0;
    s_vec_wr_en         = 1'b0;
    s_wr_reg            = '0;
    s_reg_data          = '0;
    s_vec_data          = '0;
    v_reg_wr_en         = 1'b0;
    v_vec_wr_en         = 1'b0;
    v_wr_reg            = '0;
    v_reg_data          = '0;
    v_vec_data          = '0;
    register_wb_sel     = 1'b0;
    vector_wb_sel       = 1'b0;
    buffer_register     = 1'b0;
    buffer_vector       = 1'b0;
    buffer_register_sel = 1'b0;
    buffer_vector_sel   = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    idle();
    s_reg_wr_en     = v.s_reg_wr_en;
    s_vec_wr_en     = v.s_vec_wr_en;
    s_wr_reg        = v.s_wr_reg;
    s_reg_data      = v.s_reg_data;
    s_vec_data      = v.s_vec_data;
    v_reg_wr_en     = v.v_reg_wr_en;
    v_vec_wr_en     = v.v_vec_wr_en;
    v_wr_reg        = v.v_wr_reg;
    v_reg_data      = v.v_reg_data;
    v_vec_data      = v.v_vec_data;
    register_wb_sel = v.register_wb_sel;
    vector_wb_sel   = v.vector_wb_sel;
  endtask

  task automatic chk_rf(input string nm, input logic [4:0] a, input logic [31:0] d);
    chk({nm, " rf_en"}, rf_wr_en, 1'b1);
    chk({nm, " rf_addr"}, rf_wr_addr, a);
    chk({nm, " rf_data"}, rf_wr_data, d);
  endtask

  task automatic chk_vrf(input string nm, input logic [4:0] a, input logic [127:0] d);
    chk({nm, " vrf_en"}, vrf_wr_en, 1'b1);
    chk({nm, " vrf_addr"}, vrf_wr_addr, a);
    chk({nm, " vrf_data"}, vrf_wr_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // 0: scalar-only RF write
    v = '{default: '0}; v.s_reg_wr_en = 1; v.s_wr_reg = 5; v.s_reg_data = 32'hA5;
    v.e_rf_en = 1; v.e_rf_addr = 5; v.e_rf_data = 32'hA5; tbl[0] = v;
    // 1: scalar-only VRF write
    v = '{default: '0}; v.s_vec_wr_en = 1; v.s_wr_reg = 7;
    v.s_vec_data = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    v.e_vrf_en = 1; v.e_vrf_addr = 7; v.e_vrf_data = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677; tbl[1] = v;
    // 2: vector direct on RF
    v = '{default: '0}; v.v_reg_wr_en = 1; v.register_wb_sel = 1; v.v_wr_reg = 9; v.v_reg_data = 32'hBEEF;
    v.e_rf_en = 1; v.e_rf_addr = 9; v.e_rf_data = 32'hBEEF; tbl[2] = v;
    // 3: vector direct beats scalar on RF, scalar stalls
    v = '{default: '0}; v.v_reg_wr_en = 1; v.register_wb_sel = 1; v.v_wr_reg = 10; v.v_reg_data = 32'hC0DE;
    v.s_reg_wr_en = 1; v.s_wr_reg = 2; v.s_reg_data = 32'h33;
    v.e_stall = 1; v.e_rf_en = 1; v.e_rf_addr = 10; v.e_rf_data = 32'hC0DE; tbl[3] = v;
    // 4: stalled scalar retried
    v = '{default: '0}; v.s_reg_wr_en = 1; v.s_wr_reg = 2; v.s_reg_data = 32'h33;
    v.e_rf_en = 1; v.e_rf_addr = 2; v.e_rf_data = 32'h33; tbl[4] = v;
    // 5: scalar on both ports
    v = '{default: '0}; v.s_reg_wr_en = 1; v.s_vec_wr_en = 1; v.s_wr_reg = 4;
    v.s_reg_data = 32'h10; v.s_vec_data = 128'h40;
    v.e_rf_en = 1; v.e_rf_addr = 4; v.e_rf_data = 32'h10;
    v.e_vrf_en = 1; v.e_vrf_addr = 4; v.e_vrf_data = 128'h40; tbl[5] = v;
    // 6: r0 passes through unchanged
    v = '{default: '0}; v.s_reg_wr_en = 1; v.s_wr_reg = 0; v.s_reg_data = 32'hFF;
    v.e_rf_en = 1; v.e_rf_addr = 0; v.e_rf_data = 32'hFF; tbl[6] = v;
    // 7: idle
    v = '{default: '0}; tbl[7] = v;
    // 8: vector result without a grant writes nothing
    v = '{default: '0}; v.v_reg_wr_en = 1; v.v_wr_reg = 11; v.v_reg_data = 32'h1234; tbl[8] = v;
    // 9: vector direct beats scalar on VRF
    v = '{default: '0}; v.v_vec_wr_en = 1; v.vector_wb_sel = 1; v.v_wr_reg = 14; v.v_vec_data = 128'hDEAD;
    v.s_vec_wr_en = 1; v.s_wr_reg = 15; v.s_vec_data = 128'h99;
    v.e_stall = 1; v.e_vrf_en = 1; v.e_vrf_addr = 14; v.e_vrf_data = 128'hDEAD; tbl[9] = v;
    // 10: grant without a vector result leaves the port to scalar
    v = '{default: '0}; v.register_wb_sel = 1; v.v_wr_reg = 19; v.v_reg_data = 32'hEE;
    v.s_reg_wr_en = 1; v.s_wr_reg = 16; v.s_reg_data = 32'h5;
    v.e_rf_en = 1; v.e_rf_addr = 16; v.e_rf_data = 32'h5; tbl[10] = v;
    // 11: vector direct VRF and scalar RF coexist
    v = '{default: '0}; v.v_vec_wr_en = 1; v.vector_wb_sel = 1; v.v_wr_reg = 18; v.v_vec_data = 128'h77;
    v.s_reg_wr_en = 1; v.s_wr_reg = 17; v.s_reg_data = 32'h6;
    v.e_rf_en = 1; v.e_rf_addr = 17; v.e_rf_data = 32'h6;
    v.e_vrf_en = 1; v.e_vrf_addr = 18; v.e_vrf_data = 128'h77; tbl[11] = v;

    // Reset state
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset rf_en", rf_wr_en, 1'b0);
    chk("reset rf_addr", rf_wr_addr, 5'd0);
    chk("reset rf_data", rf_wr_data, 32'd0);
    chk("reset vrf_en", vrf_wr_en, 1'b0);
    chk("reset vrf_addr", vrf_wr_addr, 5'd0);
    chk("reset vrf_data", vrf_wr_data, 128'd0);
    chk("reset buf_ovf", buf_ovf, 1'b0);
    chk("reset wb_stall", wb_stall, 1'b0);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors (buffers stay empty throughout)
    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("vec%0d stall", i), wb_stall, tbl[i].e_stall);
      tick();
      chk($sformatf("vec%0d rf_en", i), rf_wr_en, tbl[i].e_rf_en);
      if (tbl[i].e_rf_en) begin
        chk($sformatf("vec%0d rf_addr", i), rf_wr_addr, tbl[i].e_rf_addr);
        chk($sformatf("vec%0d rf_data", i), rf_wr_data, tbl[i].e_rf_data);
      end
      chk($sformatf("vec%0d vrf_en", i), vrf_wr_en, tbl[i].e_vrf_en);
      if (tbl[i].e_vrf_en) begin
        chk($sformatf("vec%0d vrf_addr", i), vrf_wr_addr, tbl[i].e_vrf_addr);
        chk($sformatf("vec%0d vrf_data", i), vrf_wr_data, tbl[i].e_vrf_data);
      end
      chk($sformatf("vec%0d ovf", i), buf_ovf, 1'b0);
    end

    // Buffer then drain
    idle();
    buffer_register = 1; v_reg_wr_en = 1; v_wr_reg = 3; v_reg_data = 32'h11;
    s_reg_wr_en = 1; s_wr_reg = 3; s_reg_data = 32'h22;
    #1;
    chk("bufdrain stall", wb_stall, 1'b0);
    tick();
    chk_rf("bufdrain scalar", 5'd3, 32'h22);
    idle();
    buffer_register_sel = 1;
    tick();
    chk_rf("bufdrain drain", 5'd3, 32'h11);
    idle();
    tick();
    chk("bufdrain empty rf_en", rf_wr_en, 1'b0);

    // Drain collides with scalar
    idle();
    buffer_register = 1; v_reg_wr_en = 1; v_wr_reg = 12; v_reg_data = 32'h77;
    tick();
    chk("collide capture rf_en", rf_wr_en, 1'b0);
    idle();
    buffer_register_sel = 1;
    s_reg_wr_en = 1; s_wr_reg = 13; s_reg_data = 32'h88;
    #1;
    chk("collide stall", wb_stall, 1'b1);
    tick();
    chk_rf("collide drain", 5'd12, 32'h77);
    buffer_register_sel = 0;
    #1;
    chk("collide retry stall", wb_stall, 1'b0);
    tick();
    chk_rf("collide retry", 5'd13, 32'h88);
    idle();
    tick();
    chk("collide idle rf_en", rf_wr_en, 1'b0);

    // Buffer request without valid vector result is ignored
    idle();
    buffer_register = 1; v_reg_wr_en = 1; v_wr_reg = 5; v_reg_data = 32'h55;
    tick();
    idle();
    buffer_register = 1; v_reg_wr_en = 0; v_wr_reg = 6; v_reg_data = 32'h66;
    s_reg_wr_en = 1; s_wr_reg = 7; s_reg_data = 32'h70;
    #1;
    chk("ignore stall", wb_stall, 1'b0);
    tick();
    chk_rf("ignore scalar", 5'd7, 32'h70);
    chk("ignore ovf", buf_ovf, 1'b0);
    idle();
    tick();
    chk_rf("ignore drain", 5'd5, 32'h55);
    tick();
    chk("ignore empty rf_en", rf_wr_en, 1'b0);

    // Overflow keeps the original entry
    idle();
    buffer_register = 1; v_reg_wr_en = 1; v_wr_reg = 20; v_reg_data = 32'hAA;
    tick();
    chk("ovf capture rf_en", rf_wr_en, 1'b0);
    chk("ovf before", buf_ovf, 1'b0);
    idle();
    buffer_register = 1; v_reg_wr_en = 1; v_wr_reg = 21; v_reg_data = 32'hBB;
    s_reg_wr_en = 1; s_wr_reg = 22; s_reg_data = 32'hCC;
    #1;
    chk("ovf stall", wb_stall, 1'b0);
    tick();
    chk_rf("ovf scalar", 5'd22, 32'hCC);
    chk("ovf set", buf_ovf, 1'b1);
    idle();
    buffer_register_sel = 1;
    tick();
    chk_rf("ovf drain", 5'd20, 32'hAA);
    chk("ovf sticky1", buf_ovf, 1'b1);
    idle();
    tick();
    chk("ovf empty rf_en", rf_wr_en, 1'b0);
    chk("ovf sticky2", buf_ovf, 1'b1);

    // VRF drain and capture in the same cycle
    idle();
    buffer_vector = 1; v_vec_wr_en = 1; v_wr_reg = 6; v_vec_data = {4{32'h1111_1111}};
    tick();
    chk("vdc capture vrf_en", vrf_wr_en, 1'b0);
    idle();
    buffer_vector = 1; buffer_vector_sel = 1; v_vec_wr_en = 1; v_wr_reg = 8;
    v_vec_data = {4{32'h2222_2222}};
    tick();
    chk_vrf("vdc old", 5'd6, {4{32'h1111_1111}});
    idle();
    tick();
    chk_vrf("vdc new", 5'd8, {4{32'h2222_2222}});
    tick();
    chk("vdc empty vrf_en", vrf_wr_en, 1'b0);

    // Reset with both buffers full and ovf set
    idle();
    buffer_register = 1; v_reg_wr_en = 1; buffer_vector = 1; v_vec_wr_en = 1;
    v_wr_reg = 25; v_reg_data = 32'h25; v_vec_data = 128'h26;
    tick();
    idle();
    rst_n = 0;
    buffer_register_sel = 1; buffer_vector_sel = 1;
    s_reg_wr_en = 1; s_vec_wr_en = 1; s_wr_reg = 1; s_reg_data = 32'h1; s_vec_data = 128'h1;
    #1;
    chk("rst stall", wb_stall, 1'b0);
    tick();
    chk("rst rf_en", rf_wr_en, 1'b0);
    chk("rst vrf_en", vrf_wr_en, 1'b0);
    chk("rst rf_addr", rf_wr_addr, 5'd0);
    chk("rst vrf_data", vrf_wr_data, 128'd0);
    chk("rst ovf", buf_ovf, 1'b0);
    idle();
    rst_n = 1;
    tick();
    chk("post rst rf_en", rf_wr_en, 1'b0);
    chk("post rst vrf_en", vrf_wr_en, 1'b0);
    tick();
    chk("post rst2 rf_en", rf_wr_en, 1'b0);
    chk("post rst2 vrf_en", vrf_wr_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_controller.md
WRITEBACK_CONTROLLER -- requirements
Module: writeback_controller

Interface
REQ-001 Parameter SCALAR_W, default 32: scalar register data width.
REQ-002 Parameter VECTOR_W, default 128: vector register data width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 s_reg_wr_en / s_vec_wr_en  in  1 each  scalar mem-stage result targets RF / VRF.
REQ-006 s_wr_reg  in  5  scalar destination register; s_reg_data in SCALAR_W; s_vec_data in VECTOR_W.
REQ-007 v_reg_wr_en / v_vec_wr_en  in  1 each  vector-pipeline tail result targets RF / VRF.
REQ-008 v_wr_reg  in  5  vector-pipeline destination; v_reg_data in SCALAR_W; v_vec_data in VECTOR_W.
REQ-009 register_wb_sel / vector_wb_sel  in  1 each  hazard unit grants this cycle's RF / VRF port to the vector pipeline.
REQ-010 buffer_register / buffer_vector  in  1 each  capture the vector-pipeline RF / VRF result into the buffer.
REQ-011 buffer_register_sel / buffer_vector_sel  in  1 each  registered drain request for the RF / VRF buffer.
REQ-012 rf_wr_en out 1, rf_wr_addr out 5, rf_wr_data out SCALAR_W: register-file write port.
REQ-013 vrf_wr_en out 1, vrf_wr_addr out 5, vrf_wr_data out VECTOR_W: vector-register-file write port.
REQ-014 wb_stall  out  1  scalar result not committed this cycle; feeds the hazard unit full-stall term.
REQ-015 buf_ovf  out  1  sticky: capture requested into a FULL buffer not draining that cycle.

Function
REQ-016 RF and VRF ports SHALL be independent, identical paths; each owns one buffer FSM, states EMPTY and FULL.
REQ-017 EMPTY->FULL on buffer_* =1: capture v_wr_reg and the port's v_* data.
REQ-018 FULL drains when buffer_*_sel=1, or when neither vector-direct nor scalar requests the port that cycle; drain with no capture -> EMPTY.
REQ-019 Drain and capture in the same cycle SHALL write the old entry, load the new one, remain FULL.
REQ-020 Capture while FULL and not draining SHALL keep the old entry, drop the new one, set buf_ovf.
REQ-021 Port priority per cycle: (1) buffer drain, (2) vector direct (*_wb_sel=1 and buffer_*=0), (3) scalar.
REQ-022 wb_stall=1 (combinational) when a scalar request on either port loses arbitration; scalar inputs are then held by the stall and retried.
REQ-023 Write-port outputs SHALL be registered: selected source at cycle N appears on rf_*/vrf_* at cycle N+1; *_wr_en=0 when no source wins.
REQ-024 Register r0 is not special-cased; the address is passed through unchanged.
REQ-025 buffer_* asserted with v_*_wr_en=0 SHALL be ignored (no capture, no ovf).

Reset
REQ-026 rst_n=0 at a rising edge: both FSMs EMPTY, rf_wr_en=vrf_wr_en=0, addresses and data 0, buf_ovf=0.
REQ-027 Reset mid-drain or with FULL buffers discards buffered results; no write issues in the cycle after reset.
REQ-028 wb_stall SHALL be 0 while rst_n=0.

Structure
REQ-029 Shared core package holds REG_ADDR_W=5, SCALAR_W, VECTOR_W and typedef wb_buf_state_t {EMPTY, FULL}.
REQ-030 One sub-module wb_buffer (parameter WIDTH), instantiated twice (RF, VRF) with FSM, entry and ovf flag; arbitration and output registers stay in writeback_controller.

Verification
REQ-031 Scalar-only: s_reg_wr_en=1, s_wr_reg=5, s_reg_data=0xA5 -> next cycle rf_wr_en=1, addr 5, data 0xA5; wb_stall=0.
REQ-032 Buffer then drain: cycle N buffer_register=1, v_wr_reg=3, v_reg_data=0x11, scalar to reg 3 data 0x22 -> N+1 RF writes 0x22; N+1 buffer_register_sel=1 -> N+2 RF writes 0x11 to reg 3; FSM EMPTY.
REQ-033 Drain collision: FULL buffer draining, scalar RF request same cycle -> wb_stall=1, buffer written first, scalar written next cycle.
REQ-034 Overflow: FULL, buffer_register=1, sel=0, scalar active -> buf_ovf=1 and stays 1; original entry later drains intact.
REQ-035 Simultaneous drain+capture on VRF (data 0x1.., then 0x2..) -> VRF writes old entry, FSM stays FULL holding new data.
REQ-036 rst_n=0 with both buffers FULL -> next cycle all write enables 0, buf_ovf=0, no stale drain afterward.
